// File: rtl/mnist_nn_pio_irq.sv
// Avalon-MM parallel I/O port: per-bit direction, atomic set/clear of outputs,
// synchronized + optionally debounced inputs with edge capture and a maskable
// level interrupt. Zero-wait-state slave with combinational readdata.
module mnist_nn_pio_irq #(
   parameter int unsigned      WIDTH           = 8,
   parameter int unsigned      DEBOUNCE_CYCLES = 0,
   parameter int unsigned      EDGE_TYPE       = 0,
   parameter logic [WIDTH-1:0] RESET_OUT       = '0,
   parameter logic [WIDTH-1:0] RESET_DIR       = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] oe,
   output logic             irq
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES == 0) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

   logic             wr_en;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] dir;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecap;
   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] deb;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] rd;

   // Upper writedata bits beyond WIDTH are architecturally ignored.
   logic unused_wd;
   assign unused_wd = ^writedata;

   assign wr_en = chipselect & ~write_n;
   assign wd    = writedata[WIDTH-1:0];

   // Software-visible control registers: output data, direction, interrupt mask.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= RESET_OUT;
         dir      <= RESET_DIR;
         irqmask  <= '0;
      end else if (wr_en) begin
         case (address)
            ADDR_DATA:    data_out <= wd;
            ADDR_DIR:     dir      <= wd;
            ADDR_IRQMASK: irqmask  <= wd;
            ADDR_OUTSET:  data_out <= data_out | wd;
            ADDR_OUTCLR:  data_out <= data_out & ~wd;
            default:      ;
         endcase
      end
   end

   // Two-flop synchronizer for the asynchronous pins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_no_deb
         assign deb = sync2;
      end else begin : g_deb
         logic [WIDTH-1:0] deb_q;
         logic [CNT_W-1:0] cnt [WIDTH];

         // Per-bit counter: accept a new level only after N consecutive differing cycles.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               deb_q <= '0;
               for (int i = 0; i < int'(WIDTH); i++) cnt[i] <= '0;
            end else begin
               for (int i = 0; i < int'(WIDTH); i++) begin
                  if (sync2[i] == deb_q[i]) begin
                     cnt[i] <= '0;
                  end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                     deb_q[i] <= sync2[i];
                     cnt[i]   <= '0;
                  end else begin
                     cnt[i] <= cnt[i] + CNT_W'(1);
                  end
               end
            end
         end

         assign deb = deb_q;
      end
   endgenerate

   // Previous debounced level for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) prev <= '0;
      else          prev <= deb;
   end

   // Edge selection; bits configured as outputs never capture.
   always_comb begin
      edge_det = '0;
      if (EDGE_TYPE == 0)      edge_det = deb & ~prev;
      else if (EDGE_TYPE == 1) edge_det = ~deb & prev;
      else                     edge_det = deb ^ prev;
      edge_det = edge_det & ~dir;
   end

   assign clr = (wr_en && (address == ADDR_EDGECAP)) ? wd : '0;

   // Edge capture with write-1-to-clear; a same-cycle edge beats the clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) edgecap <= '0;
      else          edgecap <= (edgecap & ~clr) | edge_det;
   end

   assign irq      = |(edgecap & irqmask);
   assign out_port = data_out;
   assign oe       = dir;

   // Combinational read mux; no read side effects.
   always_comb begin
      rd = '0;
      case (address)
         ADDR_DATA:    rd = (dir & data_out) | (~dir & deb);
         ADDR_DIR:     rd = dir;
         ADDR_IRQMASK: rd = irqmask;
         ADDR_EDGECAP: rd = edgecap;
         default:      rd = '0;
      endcase
      readdata = 32'(rd);
   end

endmodule

// File: tb/tb_mnist_nn_pio_irq.sv
// Bench for mnist_nn_pio_irq: register-map vector table, hand-written latency
// and corner sequences, and randomized input traffic against a delay-line model.
module tb_mnist_nn_pio_irq;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [2:0]   address;
   logic         write_n;
   logic [31:0]  writedata;
   logic [2:0]   cs;
   logic [W-1:0] in_p  [3];
   logic [31:0]  rd    [3];
   logic [W-1:0] out_p [3];
   logic [W-1:0] oe_p  [3];
   logic [2:0]   irq_v;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // A: no debounce, rising edge, non-zero reset values
   mnist_nn_pio_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0),
                      .RESET_OUT(8'hA5), .RESET_DIR(8'hFF)) u_a (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]),
      .write_n(write_n), .writedata(writedata), .readdata(rd[0]),
      .in_port(in_p[0]), .out_port(out_p[0]), .oe(oe_p[0]), .irq(irq_v[0]));

   // B: 4-cycle debounce, rising edge
   mnist_nn_pio_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0),
                      .RESET_OUT(8'h00), .RESET_DIR(8'h00)) u_b (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]),
      .write_n(write_n), .writedata(writedata), .readdata(rd[1]),
      .in_port(in_p[1]), .out_port(out_p[1]), .oe(oe_p[1]), .irq(irq_v[1]));

   // C: no debounce, any edge
   mnist_nn_pio_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2),
                      .RESET_OUT(8'h00), .RESET_DIR(8'h00)) u_c (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]),
      .write_n(write_n), .writedata(writedata), .readdata(rd[2]),
      .in_port(in_p[2]), .out_port(out_p[2]), .oe(oe_p[2]), .irq(irq_v[2]));

   typedef struct {
      logic [2:0]  addr;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;   // readdata before the write takes effect
      logic [7:0]  exp_out;  // out_port after the clock edge
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic bus(input int d, input logic [2:0] a, input logic wr, input logic [31:0] wd);
      cs        = 3'(1 << d);
      address   = a;
      write_n   = ~wr;
      writedata = wd;
   endtask

   task automatic idle();
      cs      = '0;
      write_n = 1'b1;
   endtask

   // Advance n clocks, leaving time just after the rising edge.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Random traffic on DUT d with all bits as inputs; the model treats the
   // input path as a pure delay of (1 + N) edges, valid because each input
   // value is held for at least N cycles.
   task automatic random_phase(input int d, input int n_deb, input int cycles);
      logic [W-1:0] hist[$];
      logic [W-1:0] m_deb, m_prev, m_ec, mask, clr_v;
      int hold;
      int op;
      in_p[d] = '0;
      idle();
      cyc(n_deb + 6);
      bus(d, 3'd3, 1'b1, 32'hFF);
      cyc(1);
      mask = W'($urandom);
      bus(d, 3'd2, 1'b1, 32'(mask));
      cyc(1);
      idle();
      hist.delete();
      for (int i = 0; i < n_deb + 2; i++) hist.push_back('0);
      m_deb = '0; m_prev = '0; m_ec = '0;
      hold = 0;
      for (int c = 0; c < cycles; c++) begin
         if (hold == 0) begin
            in_p[d] = W'($urandom);
            hold = (n_deb == 0) ? int'($urandom_range(1, 2))
                                : int'($urandom_range(n_deb, n_deb + 3));
         end
         hold--;
         op = int'($urandom_range(0, 2));
         if (op == 0)      bus(d, 3'd0, 1'b0, 32'h0);
         else if (op == 1) bus(d, 3'd3, 1'b0, 32'h0);
         else              bus(d, 3'd3, 1'b1, $urandom);
         @(negedge clk);
         chk($sformatf("rand%0d c%0d rd a%0d", d, c, address), rd[d],
             (address == 3'd0) ? 32'(m_deb) : 32'(m_ec));
         chk($sformatf("rand%0d c%0d irq", d, c), 32'(irq_v[d]), 32'(|(m_ec & mask)));
         @(posedge clk);
         clr_v = (!write_n && address == 3'd3) ? writedata[W-1:0] : '0;
         m_ec = (m_ec & ~clr_v) | (m_deb & ~m_prev);
         hist.push_back(in_p[d]);
         m_prev = m_deb;
         m_deb  = hist[1];
         void'(hist.pop_front());
         #1;
      end
      idle();
   endtask

   initial begin
      reset_n   = 1'b0;
      address   = '0;
      write_n   = 1'b1;
      writedata = '0;
      cs        = '0;
      for (int i = 0; i < 3; i++) in_p[i] = '0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);

      // Reset state
      chk("reset out_a", 32'(out_p[0]), 32'hA5);
      chk("reset oe_a",  32'(oe_p[0]),  32'hFF);
      chk("reset irq",   32'(irq_v),    32'h0);
      chk("reset out_b", 32'(out_p[1]), 32'h00);
      chk("reset oe_b",  32'(oe_p[1]),  32'h00);
      @(posedge clk); #1;

      // Register-map table on DUT A
      tbl.push_back('{3'd0, 1'b0, 32'h0, 32'hA5, 8'hA5});
      tbl.push_back('{3'd1, 1'b0, 32'h0, 32'hFF, 8'hA5});
      tbl.push_back('{3'd2, 1'b0, 32'h0, 32'h00, 8'hA5});
      tbl.push_back('{3'd3, 1'b0, 32'h0, 32'h00, 8'hA5});
      tbl.push_back('{3'd4, 1'b0, 32'h0, 32'h00, 8'hA5});
      tbl.push_back('{3'd5, 1'b0, 32'h0, 32'h00, 8'hA5});
      tbl.push_back('{3'd6, 1'b0, 32'h0, 32'h00, 8'hA5});
      tbl.push_back('{3'd7, 1'b0, 32'h0, 32'h00, 8'hA5});
      tbl.push_back('{3'd0, 1'b1, 32'h0F, 32'hA5, 8'h0F});
      tbl.push_back('{3'd4, 1'b1, 32'h30, 32'h00, 8'h3F});
      tbl.push_back('{3'd5, 1'b1, 32'h05, 32'h00, 8'h3A});
      tbl.push_back('{3'd6, 1'b1, 32'hFF, 32'h00, 8'h3A});
      tbl.push_back('{3'd7, 1'b1, 32'hFF, 32'h00, 8'h3A});
      tbl.push_back('{3'd0, 1'b0, 32'h0, 32'h3A, 8'h3A});
      tbl.push_back('{3'd1, 1'b1, 32'h00, 32'hFF, 8'h3A});
      tbl.push_back('{3'd0, 1'b0, 32'h0, 32'h00, 8'h3A});
      tbl.push_back('{3'd1, 1'b0, 32'h0, 32'h00, 8'h3A});
      tbl.push_back('{3'd2, 1'b1, 32'hFFFFFF01, 32'h00, 8'h3A});
      tbl.push_back('{3'd2, 1'b0, 32'h0, 32'h01, 8'h3A});
      tbl.push_back('{3'd1, 1'b1, 32'hABCD120F, 32'h00, 8'h3A});
      tbl.push_back('{3'd0, 1'b0, 32'h0, 32'h0A, 8'h3A});
      tbl.push_back('{3'd1, 1'b1, 32'h00, 32'h0F, 8'h3A});
      tbl.push_back('{3'd0, 1'b0, 32'h0, 32'h00, 8'h3A});
      for (int i = 0; i < tbl.size(); i++) begin
         bus(0, tbl[i].addr, tbl[i].wr, tbl[i].wdata);
         @(negedge clk);
         chk($sformatf("tbl%0d rd", i), rd[0], tbl[i].exp_rd);
         @(posedge clk); #1;
         chk($sformatf("tbl%0d out", i), 32'(out_p[0]), 32'(tbl[i].exp_out));
      end
      idle();

      // DUT A: rising-edge latency (irqmask = 01, dir = 0)
      address = 3'd3;
      in_p[0] = 8'h01;
      @(posedge clk);            // E1
      @(posedge clk);            // E2
      @(negedge clk);
      chk("lat E2 edgecap", rd[0], 32'h00);
      chk("lat E2 irq", 32'(irq_v[0]), 32'h0);
      @(posedge clk);            // E3
      @(negedge clk);
      chk("lat E3 edgecap", rd[0], 32'h01);
      chk("lat E3 irq", 32'(irq_v[0]), 32'h1);
      @(posedge clk); #1;
      in_p[0] = 8'h00;
      cyc(6);
      chk("fall no capture", rd[0], 32'h01);

      // Clear and new edge in the same cycle: edge wins
      in_p[0] = 8'h01;
      cyc(2);
      bus(0, 3'd3, 1'b1, 32'h01);
      @(negedge clk);
      chk("clr+edge pre", rd[0], 32'h01);
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      chk("clr+edge edgecap", rd[0], 32'h01);
      chk("clr+edge irq", 32'(irq_v[0]), 32'h1);
      cyc(3);
      bus(0, 3'd3, 1'b1, 32'h01);
      cyc(1);
      idle();
      @(negedge clk);
      chk("clr only edgecap", rd[0], 32'h00);
      chk("clr only irq", 32'(irq_v[0]), 32'h0);
      @(posedge clk); #1;
      in_p[0] = 8'h00;

      // DUT B: 3-cycle glitch rejected by the debouncer
      address = 3'd0;
      in_p[1] = 8'h04;
      cyc(3);
      in_p[1] = 8'h00;
      cyc(10);
      @(negedge clk);
      chk("glitch data", rd[1], 32'h00);
      address = 3'd3;
      #1;
      chk("glitch edgecap", rd[1], 32'h00);
      @(posedge clk); #1;

      // DUT B: 6-cycle pulse accepted, capture after 2+4+1 edges
      in_p[1] = 8'h04;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk);
         #1;
         if (k == 6) in_p[1] = 8'h00;
         @(negedge clk);
         if (k == 6) chk("pulse E6 edgecap", rd[1], 32'h00);
         if (k == 7) chk("pulse E7 edgecap", rd[1], 32'h04);
      end
      address = 3'd0;
      #1;
      chk("pulse E7 data", rd[1], 32'h04);
      chk("pulse masked irq", 32'(irq_v[1]), 32'h0);
      cyc(12);

      // DUT C: any-edge capture limited to input bits, then late unmask
      bus(2, 3'd1, 1'b1, 32'h0F);
      cyc(1);
      idle();
      chk("C oe", 32'(oe_p[2]), 32'h0F);
      address = 3'd3;
      in_p[2] = 8'hFF;
      cyc(5);
      @(negedge clk);
      chk("C rise edgecap", rd[2], 32'hF0);
      chk("C masked irq", 32'(irq_v[2]), 32'h0);
      @(posedge clk); #1;
      in_p[2] = 8'h00;
      cyc(5);
      @(negedge clk);
      chk("C fall edgecap", rd[2], 32'hF0);
      @(posedge clk); #1;
      bus(2, 3'd2, 1'b1, 32'h80);
      @(negedge clk);
      chk("C pre-unmask irq", 32'(irq_v[2]), 32'h0);
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      chk("C unmask irq", 32'(irq_v[2]), 32'h1);
      @(posedge clk); #1;

      // Randomized traffic against the model
      random_phase(0, 0, 300);
      random_phase(1, 4, 300);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
